// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared FSM states, SPI command codes and default width for the SPI-to-RAM path
package spi_ram_pkg;
  localparam int DEF_ADDR_SIZE = 8;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
endpackage

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: loads one read byte and shifts it out MSB first, one bit per clk
module spi_tx_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         miso,
  output logic         busy,
  output logic         done,
  output logic         fin
);
  logic [W-1:0] sh;
  logic [2:0]   tcnt;
  assign fin = busy && tcnt == 3'(W - 1);
  // MSB goes out on the load edge; the remaining bits follow, then the line returns to 0
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sh   <= '0;
      tcnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      miso <= 1'b0;
    end else if (load) begin
      sh   <= {din[W-2:0], 1'b0};
      miso <= din[W-1];
      tcnt <= '0;
      busy <= 1'b1;
    end else if (fin) begin
      miso <= 1'b0;
      busy <= 1'b0;
      done <= 1'b1;
    end else if (busy) begin
      miso <= sh[W-1];
      sh   <= {sh[W-2:0], 1'b0};
      tcnt <= tcnt + 3'd1;
    end
  end
endmodule

// File: rtl/spi_slave_frontend.sv
// spi_slave_frontend: SPI slave that turns 10-bit frames into RAM words and returns read bytes on MISO
module spi_slave_frontend
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);
  localparam int FB = ADDR_SIZE + 2;
  state_t          state, next;
  logic [3:0]      cnt;
  logic [FB-1:0]   shift;
  logic            rd_addr_seen, shift_en, last, load, clr, busy, done, fin;
  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  // Next state and datapath strobes; SS_n high aborts from any state
  always_comb begin
    next     = state;
    shift_en = 1'b0;
    last     = 1'b0;
    load     = 1'b0;
    if (SS_n) next = IDLE;
    else if (state == IDLE) next = CHK_CMD;
    else if (state == CHK_CMD) next = MOSI ? (rd_addr_seen ? READ_DATA : READ_ADD) : WRITE;
    else begin
      shift_en = cnt != 4'(FB);
      last     = cnt == 4'(FB - 1);
      load     = state == READ_DATA && cnt == 4'(FB) && tx_valid && !busy && !done;
    end
    clr = SS_n || state != READ_DATA;
  end
  // Receive shifter, frame bit counter, rx strobe and read-address tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= last;
      if (last) rx_data <= {shift[FB-2:0], MOSI};
      if (shift_en) shift <= {shift[FB-2:0], MOSI};
      if (SS_n || state == CHK_CMD) cnt <= '0;
      else if (shift_en) cnt <= cnt + 4'd1;
      if (last && state == READ_ADD) rd_addr_seen <= 1'b1;
      else if (fin && !SS_n) rd_addr_seen <= 1'b0;
    end
  end
  spi_tx_serializer #(.W(ADDR_SIZE)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (load),
    .din   (tx_data),
    .miso  (MISO),
    .busy  (busy),
    .done  (done),
    .fin   (fin)
  );
endmodule

// File: tb/tb_spi_slave_frontend.sv
// tb_spi_slave_frontend: directed checks of framing, rx strobe, read serialisation and aborts
module tb_spi_slave_frontend;
  import spi_ram_pkg::*;
  logic       clk, rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;
  int checks = 0, failures = 0;
  spi_slave_frontend dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic c, input logic [9:0] p);
    int early;
    early = 0;
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick;
    MOSI = c;
    tick;
    for (int i = 9; i >= 0; i--) begin
      MOSI = p[i];
      tick;
      if (i > 0) early += int'(rx_valid);
    end
    chk("early_valid", early, 0);
    chk("rx_valid_10th", rx_valid, 1);
    chk("rx_data", rx_data, p);
    MOSI = 1'b0;
    tick;
    chk("rx_valid_drop", rx_valid, 0);
  endtask
  initial begin
    int v;
    logic [9:0] bits;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick; tick;
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_miso", MISO, 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    SS_n = 1'b0; tick;
    MOSI = 1'b1; tick;
    for (int i = 0; i < 5; i++) begin MOSI = 1'b1; tick; end
    rst_n = 1'b0; tick;
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_miso", MISO, 0);
    chk("midrst_rd_seen", dut.rd_addr_seen, 0);
    rst_n = 1'b1; SS_n = 1'b1;
    v = 0;
    for (int i = 0; i < 12; i++) begin MOSI = 1'b1; tick; v += int'(rx_valid); end
    chk("midrst_no_valid", v, 0);
    frame(1'b0, {CMD_WR_ADDR, 8'hA5});
    SS_n = 1'b1; tick;
    frame(1'b0, {CMD_WR_DATA, 8'h3C});
    chk("wr_data_val", rx_data, 10'h13C);
    SS_n = 1'b1; tick;
    frame(1'b1, {CMD_RD_ADDR, 8'hA5});
    chk("rd_addr_val", rx_data, 10'h2A5);
    chk("rd_seen_set", dut.rd_addr_seen, 1);
    SS_n = 1'b1; tick;
    chk("rd_seen_keep", dut.rd_addr_seen, 1);
    frame(1'b1, {CMD_RD_DATA, 8'h00});
    chk("rd_data_val", rx_data, 10'h300);
    chk("rd_state", 32'(dut.state), 32'(READ_DATA));
    chk("miso_wait", MISO, 0);
    tx_valid = 1'b1; tx_data = 8'h3C; tick;
    chk("miso_b7", MISO, 0);
    tx_valid = 1'b0; tx_data = 8'h00;
    bits = 10'b00_0011_1100;
    for (int i = 6; i >= 0; i--) begin
      tick;
      chk($sformatf("miso_b%0d", i), MISO, bits[i]);
    end
    tick;
    chk("miso_after", MISO, 0);
    chk("rd_seen_clr", dut.rd_addr_seen, 0);
    tx_valid = 1'b1; tx_data = 8'hFF; tick; tick;
    chk("miso_no_reload", MISO, 0);
    tx_valid = 1'b0;
    SS_n = 1'b1; tick;
    SS_n = 1'b0; MOSI = 1'b0; tick;
    MOSI = 1'b1; tick;
    for (int i = 0; i < 9; i++) begin MOSI = 1'b1; tick; end
    SS_n = 1'b1; tick;
    chk("abort_valid", rx_valid, 0);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    tick;
    chk("abort_valid2", rx_valid, 0);
    chk("abort_hold", rx_data, 10'h300);
    SS_n = 1'b0; MOSI = 1'b0; tick;
    MOSI = 1'b0; tick;
    bits = 10'h155;
    v = 0;
    for (int i = 9; i >= 0; i--) begin MOSI = bits[i]; tick; v += int'(rx_valid); end
    for (int i = 0; i < 4; i++) begin MOSI = 1'b1; tick; v += int'(rx_valid); end
    tick; v += int'(rx_valid);
    chk("extra_pulses", v, 1);
    chk("extra_data", rx_data, 10'h155);
    SS_n = 1'b1; tick;
    tx_valid = 1'b1; tx_data = 8'hFF;
    v = 0;
    for (int i = 0; i < 4; i++) begin tick; v += int'(MISO); end
    chk("idle_tx_ignored", v, 0);
    tx_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
